pipe_collision_scorer: RTL and testbench

Parametrised successor to the single-pipe game-state checker. It checks the bird's bounding box against N_PIPES pipe channels and against the floor, and keeps a saturating score of pipes passed. It runs the Initial/Check/Lose game FSM with a Start/Ack handshake. It sits between the pipe generator/scroller and the VGA/score display logic.

---
 rtl/pipe_collision_scorer.sv | 157 +++++++++++++++
 tb/tb_pipe_collision_scorer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_collision_scorer.sv
// Bird-vs-pipes collision checker and pass scorer.
// Runs the Initial/Check/Lose game FSM with a Start/Ack handshake.
module pipe_collision_scorer #(
    parameter int N_PIPES = 4,
    parameter int XW      = 10,
    parameter int YW      = 10,
    parameter int PIPE_W  = 80,
    parameter int GAP_H   = 100,
    parameter int BIRD_W  = 16,
    parameter int BIRD_H  = 16,
    parameter int FLOOR_Y = 470,
    parameter int SCORE_W = 8,
    localparam int IW = (N_PIPES > 1) ? $clog2(N_PIPES) : 1
) (
    input  logic                  Clk,
    input  logic                  reset_n,
    input  logic                  Start,
    input  logic                  Ack,
    input  logic [XW-1:0]         Bird_X,
    input  logic [YW-1:0]         Bird_Y,
    input  logic [N_PIPES*XW-1:0] Pipe_X,
    input  logic [N_PIPES*YW-1:0] Pipe_Y,
    input  logic [N_PIPES-1:0]    Pipe_Valid,
    output logic                  Q_Initial,
    output logic                  Q_Check,
    output logic                  Q_Lose,
    output logic                  Lose,
    output logic                  Hit_Floor,
    output logic [IW-1:0]         Hit_Index,
    output logic [SCORE_W-1:0]    Score,
    output logic                  Score_Pulse
);

    localparam int CW = ((XW > YW) ? XW : YW) + 1;

    typedef enum logic [1:0] {
        QInitial = 2'd0,
        QCheck   = 2'd1,
        QLose    = 2'd2
    } state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic [N_PIPES-1:0] passed;

    logic [XW-1:0] sel_x;
    logic [YW-1:0] sel_y;
    logic          sel_v;
    logic          sel_p;

    logic [CW-1:0] bx, by, px, py;
    logic          x_ovl, y_vio, pipe_hit, floor_hit, behind, score_full;

    // Select the channel currently under the scanner.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_v = 1'b0;
        sel_p = 1'b0;
        for (int i = 0; i < N_PIPES; i++) begin
            if (idx == IW'(i)) begin
                sel_x = Pipe_X[i*XW +: XW];
                sel_y = Pipe_Y[i*YW +: YW];
                sel_v = Pipe_Valid[i];
                sel_p = passed[i];
            end
        end
    end

    // Geometry in one extra bit so the sums never wrap.
    always_comb begin
        bx = CW'(Bird_X);
        by = CW'(Bird_Y);
        px = CW'(sel_x);
        py = CW'(sel_y);
        x_ovl = (bx + CW'(BIRD_W) > px) && (bx < px + CW'(PIPE_W));
        y_vio = (by < py) || (by + CW'(BIRD_H) > py + CW'(GAP_H));
        pipe_hit  = sel_v && x_ovl && y_vio;
        floor_hit = by + CW'(BIRD_H) > CW'(FLOOR_Y);
        behind    = px + CW'(PIPE_W) <= bx;
        score_full = &Score;
    end

    // Game FSM, scanner, pass flags and score with registered outputs.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= QInitial;
            Q_Initial   <= 1'b1;
            Q_Check     <= 1'b0;
            Q_Lose      <= 1'b0;
            Lose        <= 1'b0;
            Hit_Floor   <= 1'b0;
            Hit_Index   <= '0;
            Score       <= '0;
            Score_Pulse <= 1'b0;
            idx         <= '0;
            passed      <= '0;
        end else begin
            Score_Pulse <= 1'b0;
            case (state)
                QInitial: begin
                    if (Start) begin
                        state     <= QCheck;
                        Q_Initial <= 1'b0;
                        Q_Check   <= 1'b1;
                        Score     <= '0;
                        passed    <= '0;
                        idx       <= '0;
                        Hit_Floor <= 1'b0;
                        Hit_Index <= '0;
                    end
                end
                QCheck: begin
                    if (idx == IW'(N_PIPES - 1)) begin
                        idx <= '0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                    if (floor_hit || pipe_hit) begin
                        state     <= QLose;
                        Q_Check   <= 1'b0;
                        Q_Lose    <= 1'b1;
                        Lose      <= 1'b1;
                        Hit_Floor <= floor_hit;
                        Hit_Index <= pipe_hit ? idx : '0;
                    end else if (sel_v && behind) begin
                        if (!sel_p) begin
                            passed[idx] <= 1'b1;
                            if (!score_full) begin
                                Score       <= Score + SCORE_W'(1);
                                Score_Pulse <= 1'b1;
                            end
                        end
                    end else begin
                        passed[idx] <= 1'b0;
                    end
                end
                QLose: begin
                    if (Ack) begin
                        state     <= QInitial;
                        Q_Lose    <= 1'b0;
                        Lose      <= 1'b0;
                        Q_Initial <= 1'b1;
                    end
                end
                default: begin
                    state     <= QInitial;
                    Q_Initial <= 1'b1;
                    Q_Check   <= 1'b0;
                    Q_Lose    <= 1'b0;
                    Lose      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_collision_scorer.sv
// Directed bench for pipe_collision_scorer.
// A second instance with a 2-bit score shares all inputs.
module tb_pipe_collision_scorer;

    logic        Clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        Start = 1'b0;
    logic        Ack = 1'b0;
    logic [9:0]  Bird_X = 10'd300;
    logic [9:0]  Bird_Y = 10'd200;
    logic [39:0] Pipe_X = '0;
    logic [39:0] Pipe_Y = '0;
    logic [3:0]  Pipe_Valid = '0;

    logic       Q_Initial, Q_Check, Q_Lose, Lose, Hit_Floor, Score_Pulse;
    logic [1:0] Hit_Index;
    logic [7:0] Score;

    logic       s_Q_Initial, s_Q_Check, s_Q_Lose, s_Lose;
    logic       s_Hit_Floor, s_Score_Pulse;
    logic [1:0] s_Hit_Index;
    logic [1:0] s_Score;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;
    int edges;

    pipe_collision_scorer dut (
        .Clk(Clk), .reset_n(reset_n), .Start(Start), .Ack(Ack),
        .Bird_X(Bird_X), .Bird_Y(Bird_Y), .Pipe_X(Pipe_X),
        .Pipe_Y(Pipe_Y), .Pipe_Valid(Pipe_Valid),
        .Q_Initial(Q_Initial), .Q_Check(Q_Check), .Q_Lose(Q_Lose),
        .Lose(Lose), .Hit_Floor(Hit_Floor), .Hit_Index(Hit_Index),
        .Score(Score), .Score_Pulse(Score_Pulse)
    );

    pipe_collision_scorer #(.SCORE_W(2)) dut_sat (
        .Clk(Clk), .reset_n(reset_n), .Start(Start), .Ack(Ack),
        .Bird_X(Bird_X), .Bird_Y(Bird_Y), .Pipe_X(Pipe_X),
        .Pipe_Y(Pipe_Y), .Pipe_Valid(Pipe_Valid),
        .Q_Initial(s_Q_Initial), .Q_Check(s_Q_Check), .Q_Lose(s_Q_Lose),
        .Lose(s_Lose), .Hit_Floor(s_Hit_Floor), .Hit_Index(s_Hit_Index),
        .Score(s_Score), .Score_Pulse(s_Score_Pulse)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (Score_Pulse) pulses++;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_pipe(input int ch, input logic [9:0] x,
                            input logic [9:0] y);
        Pipe_X[ch*10 +: 10] = x;
        Pipe_Y[ch*10 +: 10] = y;
    endtask

    // One pass of channel 0: gone for a frame, then behind the bird.
    task automatic pass_once();
        Pipe_Valid = 4'b0000;
        tick(4);
        Pipe_Valid = 4'b0001;
        tick(4);
    endtask

    initial begin
        // Reset
        #3 reset_n = 1'b0;
        tick(2);
        chk("rst_q_initial", 32'(Q_Initial), 1);
        chk("rst_q_check", 32'(Q_Check), 0);
        chk("rst_q_lose", 32'(Q_Lose), 0);
        chk("rst_lose", 32'(Lose), 0);
        chk("rst_hit_floor", 32'(Hit_Floor), 0);
        chk("rst_hit_index", 32'(Hit_Index), 0);
        chk("rst_score", 32'(Score), 0);
        chk("rst_pulse", 32'(Score_Pulse), 0);
        #3 reset_n = 1'b1;
        tick(1);

        // Start, then floor loss
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        chk("start_q_check", 32'(Q_Check), 1);
        chk("start_score", 32'(Score), 0);
        chk("start_lose", 32'(Lose), 0);
        tick(2);
        chk("start_still_check", 32'(Q_Check), 1);
        Bird_Y = 10'd460;
        tick(1);
        chk("floor_q_lose", 32'(Q_Lose), 1);
        chk("floor_lose", 32'(Lose), 1);
        chk("floor_hit_floor", 32'(Hit_Floor), 1);
        chk("floor_hit_index", 32'(Hit_Index), 0);
        Start = 1'b1;
        tick(2);
        Start = 1'b0;
        chk("lose_ignores_start", 32'(Q_Lose), 1);
        Ack = 1'b1;
        tick(1);
        Ack = 1'b0;
        chk("ack_q_initial", 32'(Q_Initial), 1);
        chk("ack_lose", 32'(Lose), 0);
        chk("ack_hit_floor_held", 32'(Hit_Floor), 1);

        // Pipe hit on channel 2
        Bird_X = 10'd110;
        Bird_Y = 10'd150;
        set_pipe(2, 10'd100, 10'd200);
        Pipe_Valid = 4'b0100;
        Start = 1'b1;
        edges = 0;
        for (int k = 0; k < 8 && !Q_Lose; k++) begin
            tick(1);
            Start = 1'b0;
            edges++;
        end
        chk("hit_q_lose", 32'(Q_Lose), 1);
        chk("hit_latency_ok", 32'(edges <= 5), 1);
        chk("hit_index", 32'(Hit_Index), 2);
        chk("hit_floor_clear", 32'(Hit_Floor), 0);
        Ack = 1'b1;
        tick(1);
        Ack = 1'b0;

        // Clean pass through channel 0
        Pipe_Valid = 4'b0000;
        Bird_X = 10'd200;
        Bird_Y = 10'd230;
        set_pipe(0, 10'd150, 10'd200);
        Pipe_Valid = 4'b0001;
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        chk("pass_start_score", 32'(Score), 0);
        pulses = 0;
        tick(4);
        set_pipe(0, 10'd135, 10'd200);
        tick(4);
        set_pipe(0, 10'd121, 10'd200);
        tick(4);
        chk("pass_no_loss", 32'(Q_Check), 1);
        chk("pass_not_yet", 32'(Score), 0);
        chk("pass_no_pulse", 32'(pulses), 0);
        set_pipe(0, 10'd104, 10'd200);
        tick(8);
        chk("pass_score_1", 32'(Score), 1);
        chk("pass_one_pulse", 32'(pulses), 1);
        tick(12);
        chk("pass_hold_score", 32'(Score), 1);
        chk("pass_hold_pulse", 32'(pulses), 1);
        pass_once();
        chk("rearm_score_2", 32'(Score), 2);
        chk("rearm_pulses", 32'(pulses), 2);

        // Saturation on the 2-bit instance
        pass_once();
        pass_once();
        pass_once();
        chk("sat_main_5", 32'(Score), 5);
        chk("sat_score_3", 32'(s_Score), 3);
        pass_once();
        chk("sat_main_6", 32'(Score), 6);
        chk("sat_stays_3", 32'(s_Score), 3);
        chk("sat_check_alive", 32'(Q_Check), 1);

        // Pass and floor hit on the same edge
        Pipe_Valid = 4'b0000;
        for (int c = 0; c < 4; c++) set_pipe(c, 10'd104, 10'd200);
        tick(4);
        Pipe_Valid = 4'b1111;
        Bird_Y = 10'd460;
        tick(1);
        chk("prio_q_lose", 32'(Q_Lose), 1);
        chk("prio_score", 32'(Score), 6);
        chk("prio_no_pulse", 32'(Score_Pulse), 0);
        chk("prio_hit_floor", 32'(Hit_Floor), 1);
        chk("prio_hit_index", 32'(Hit_Index), 0);
        Ack = 1'b1;
        tick(1);
        Ack = 1'b0;
        tick(1);
        chk("score_held_initial", 32'(Score), 6);

        // Async reset mid-game with Score=2
        Bird_Y = 10'd230;
        Pipe_Valid = 4'b0000;
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        chk("restart_score_0", 32'(Score), 0);
        pass_once();
        pass_once();
        chk("pre_reset_score", 32'(Score), 2);
        chk("pre_reset_check", 32'(Q_Check), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_q_initial", 32'(Q_Initial), 1);
        chk("areset_q_check", 32'(Q_Check), 0);
        chk("areset_score", 32'(Score), 0);
        tick(1);
        reset_n = 1'b1;
        tick(2);
        chk("after_reset_idle", 32'(Q_Initial), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
